cmd_responder: RTL and testbench

- Cluster-side endpoint of the HPU command path. Accepts cmd_req_t from a command frontend over valid/ready.
- Allocates a tag per accepted command and dispatches it to one of NUM_INTF execution interfaces, selected by intf_id.
- Collects per-interface completions and returns one cmd_resp_t per command as a single-cycle cmd_resp_valid_o pulse. There is no backpressure on the response.

---
 rtl/cmd_responder.sv | 187 ++++++++++++++++++
 tb/tb_cmd_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_responder.sv
// cmd_responder: cluster-side endpoint of the HPU command path.
// Tags commands, dispatches them to execution interfaces, returns responses.
package cmd_responder_pkg;

  typedef struct packed {
    logic [7:0]  cmd_id;
    logic [3:0]  cmd_type;
    logic [3:0]  intf_id;
    logic [31:0] descr;
  } cmd_req_t;

  typedef struct packed {
    logic [7:0] cmd_id;
  } cmd_resp_t;

endpackage

module cmd_responder
  import cmd_responder_pkg::*;
#(
  parameter int NUM_INTF        = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_WIDTH       = $clog2(MAX_OUTSTANDING)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  cmd_req_t                      cmd_i,
  output logic                          cmd_resp_valid_o,
  output cmd_resp_t                     cmd_resp_o,
  output logic [NUM_INTF-1:0]           intf_req_valid_o,
  input  logic [NUM_INTF-1:0]           intf_req_ready_i,
  output cmd_req_t                      intf_req_o,
  output logic [TAG_WIDTH-1:0]          intf_req_tag_o,
  input  logic [NUM_INTF-1:0]           intf_cpl_valid_i,
  input  logic [NUM_INTF*TAG_WIDTH-1:0] intf_cpl_tag_i,
  output logic                          idle_o,
  output logic                          spurious_cpl_o
);

  localparam int N = MAX_OUTSTANDING;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_QUEUED = 2'd1;
  localparam logic [1:0] S_DISP   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           st_q [N];
  logic [7:0]           id_q [N];
  logic                 disp_vld_q;
  cmd_req_t             disp_req_q;
  logic [TAG_WIDTH-1:0] disp_tag_q;
  logic [NUM_INTF-1:0]  disp_sel_q;
  logic                 spur_q;
  logic                 resp_vld_q;
  cmd_resp_t            resp_q;

  logic [N-1:0]         free_v;
  logic [N-1:0]         disp_v;
  logic [N-1:0]         done_v;
  logic                 disp_hs;
  logic [TAG_WIDTH-1:0] alloc_idx;
  logic                 id_ok;
  logic [NUM_INTF-1:0]  sel_d;
  logic                 accept;
  logic                 bypass;
  logic [N-1:0]         cpl_hit;
  logic                 spur_d;
  logic [TAG_WIDTH-1:0] ctag;
  logic [N-1:0]         pend;
  logic                 pick_vld;
  logic [TAG_WIDTH-1:0] pick_idx;
  logic [7:0]           resp_id_d;

  always_comb begin
    free_v = '0;
    disp_v = '0;
    done_v = '0;
    for (int i = 0; i < N; i++) begin
      free_v[i] = st_q[i] == S_FREE;
      disp_v[i] = st_q[i] == S_DISP;
      done_v[i] = st_q[i] == S_DONE;
    end
  end

  assign intf_req_valid_o = disp_vld_q ? disp_sel_q : '0;
  assign disp_hs = |(intf_req_valid_o & intf_req_ready_i);

  always_comb begin
    alloc_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (free_v[i]) alloc_idx = TAG_WIDTH'(i);
  end

  assign id_ok = int'(cmd_i.intf_id) < NUM_INTF;

  always_comb begin
    sel_d = '0;
    for (int k = 0; k < NUM_INTF; k++)
      if (int'(cmd_i.intf_id) == k) sel_d[k] = 1'b1;
  end

  assign cmd_ready_o = ~rst_i & (|free_v)
                     & (~disp_vld_q | disp_hs);
  assign accept = cmd_valid_i & cmd_ready_o;
  assign bypass = accept & ~id_ok;

  // A slot still Queued but handshaking now counts as dispatched.
  always_comb begin
    cpl_hit = '0;
    spur_d  = 1'b0;
    ctag    = '0;
    for (int k = 0; k < NUM_INTF; k++) begin
      ctag = intf_cpl_tag_i[k*TAG_WIDTH +: TAG_WIDTH];
      if (intf_cpl_valid_i[k]) begin
        if (disp_v[ctag] || (disp_hs && ctag == disp_tag_q))
          cpl_hit[ctag] = 1'b1;
        else
          spur_d = 1'b1;
      end
    end
  end

  // Undispatchable commands complete at acceptance.
  always_comb begin
    pend = done_v | cpl_hit;
    if (bypass) pend[alloc_idx] = 1'b1;
  end

  always_comb begin
    pick_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (pend[i]) pick_idx = TAG_WIDTH'(i);
  end

  assign pick_vld  = |pend;
  assign resp_id_d = (bypass && pick_idx == alloc_idx)
                   ? cmd_i.cmd_id : id_q[pick_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        st_q[i] <= S_FREE;
        id_q[i] <= '0;
      end
      disp_vld_q <= 1'b0;
      disp_req_q <= '0;
      disp_tag_q <= '0;
      disp_sel_q <= '0;
      spur_q     <= 1'b0;
      resp_vld_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pick_vld && pick_idx == TAG_WIDTH'(i))
          st_q[i] <= S_FREE;
        else if (accept && alloc_idx == TAG_WIDTH'(i))
          st_q[i] <= id_ok ? S_QUEUED : S_DONE;
        else if (cpl_hit[i])
          st_q[i] <= S_DONE;
        else if (disp_hs && disp_tag_q == TAG_WIDTH'(i))
          st_q[i] <= S_DISP;
      end
      if (accept) id_q[alloc_idx] <= cmd_i.cmd_id;
      if (accept && id_ok) begin
        disp_vld_q <= 1'b1;
        disp_req_q <= cmd_i;
        disp_tag_q <= alloc_idx;
        disp_sel_q <= sel_d;
      end else if (disp_hs) begin
        disp_vld_q <= 1'b0;
      end
      spur_q        <= spur_q | spur_d;
      resp_vld_q    <= pick_vld;
      resp_q.cmd_id <= resp_id_d;
    end
  end

  assign intf_req_o       = disp_req_q;
  assign intf_req_tag_o   = disp_tag_q;
  assign cmd_resp_valid_o = resp_vld_q;
  assign cmd_resp_o       = resp_q;
  assign spurious_cpl_o   = spur_q;
  assign idle_o           = (&free_v) & ~disp_vld_q;

endmodule

// File: tb/tb_cmd_responder.sv
// tb_cmd_responder: scripted stimulus with a response scoreboard.
// Expected cmd_ids are queued when the completion is driven.
module tb_cmd_responder;
  import cmd_responder_pkg::*;

  localparam int NI = 2;
  localparam int MO = 8;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  cmd_req_t      cmd = '0;
  logic          resp_valid;
  cmd_resp_t     resp;
  logic [NI-1:0] rq_valid;
  logic [NI-1:0] rq_ready = '0;
  cmd_req_t      rq;
  logic [TW-1:0] rq_tag;
  logic [NI-1:0] cpl_valid = '0;
  logic [NI*TW-1:0] cpl_tag = '0;
  logic          idle;
  logic          spur;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  cmd_responder #(
    .NUM_INTF(NI),
    .MAX_OUTSTANDING(MO),
    .TAG_WIDTH(TW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_i(cmd),
    .cmd_resp_valid_o(resp_valid),
    .cmd_resp_o(resp),
    .intf_req_valid_o(rq_valid),
    .intf_req_ready_i(rq_ready),
    .intf_req_o(rq),
    .intf_req_tag_o(rq_tag),
    .intf_cpl_valid_i(cpl_valid),
    .intf_cpl_tag_i(cpl_tag),
    .idle_o(idle),
    .spurious_cpl_o(spur)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0)
        chk("resp_id", 64'(resp.cmd_id), 64'(sb.pop_front()));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic half;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] id,
                      input logic [3:0] intf);
    cmd_valid    = 1'b1;
    cmd.cmd_id   = id;
    cmd.cmd_type = 4'h1;
    cmd.intf_id  = intf;
    cmd.descr    = {24'h0, id};
  endtask

  task automatic cpl(input int k, input int tag);
    cpl_valid[k] = 1'b1;
    cpl_tag[k*TW +: TW] = TW'(tag);
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cpl_valid = '0;
    rq_ready  = '0;
    half;
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_resp", 64'(resp_valid), 64'd0);
    chk("rst_rqv", 64'(rq_valid), 64'd0);
    chk("rst_spur", 64'(spur), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    do_reset;

    // 1: single command on intf 1
    rq_ready = 2'b10;
    send(8'd3, 4'd1);
    half;
    chk("t1_ready", 64'(cmd_ready), 64'd1);
    tick;
    cmd_valid = 1'b0;
    half;
    chk("t1_rqv", 64'(rq_valid), 64'b10);
    chk("t1_tag", 64'(rq_tag), 64'd0);
    chk("t1_rqid", 64'(rq.cmd_id), 64'd3);
    chk("t1_busy", 64'(idle), 64'd0);
    tick;
    cpl(1, 0);
    sb.push_back(8'd3);
    half;
    chk("t1_rqv_off", 64'(rq_valid), 64'd0);
    chk("t1_no_resp", 64'(resp_valid), 64'd0);
    tick;
    cpl_valid = '0;
    half;
    chk("t1_resp", 64'(resp_valid), 64'd1);
    tick;
    half;
    chk("t1_resp_off", 64'(resp_valid), 64'd0);
    chk("t1_idle", 64'(idle), 64'd1);

    // 2: fill the table
    tick;
    rq_ready = 2'b01;
    for (int i = 0; i < MO; i++) begin
      send(8'(8'h10 + i), 4'd0);
      half;
      chk("t2_ready", 64'(cmd_ready), 64'd1);
      if (i > 0) begin
        chk("t2_rqv", 64'(rq_valid), 64'b01);
        chk("t2_tag", 64'(rq_tag), 64'(i - 1));
      end
      tick;
    end
    send(8'h18, 4'd0);
    half;
    chk("t2_full", 64'(cmd_ready), 64'd0);
    chk("t2_tag7", 64'(rq_tag), 64'd7);
    tick;
    cpl(0, 5);
    sb.push_back(8'h15);
    half;
    chk("t2_full2", 64'(cmd_ready), 64'd0);
    tick;
    cpl_valid = '0;
    half;
    chk("t2_resp", 64'(resp_valid), 64'd1);
    chk("t2_reopen", 64'(cmd_ready), 64'd1);
    tick;
    cmd_valid = 1'b0;
    half;
    chk("t2_re_rqv", 64'(rq_valid), 64'b01);
    chk("t2_re_tag", 64'(rq_tag), 64'd5);
    chk("t2_re_id", 64'(rq.cmd_id), 64'h18);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    tick;
    do_reset;

    // 3: simultaneous completions
    rq_ready = 2'b11;
    send(8'h20, 4'd0);
    tick;
    send(8'h21, 4'd1);
    half;
    chk("t3_tag0", 64'(rq_tag), 64'd0);
    tick;
    send(8'h22, 4'd0);
    half;
    chk("t3_rqv1", 64'(rq_valid), 64'b10);
    chk("t3_tag1", 64'(rq_tag), 64'd1);
    tick;
    cmd_valid = 1'b0;
    half;
    chk("t3_tag2", 64'(rq_tag), 64'd2);
    tick;
    cpl(0, 2);
    cpl(1, 1);
    sb.push_back(8'h21);
    sb.push_back(8'h22);
    tick;
    cpl_valid = '0;
    half;
    chk("t3_resp_a", 64'(resp_valid), 64'd1);
    tick;
    half;
    chk("t3_resp_b", 64'(resp_valid), 64'd1);
    tick;
    half;
    chk("t3_resp_off", 64'(resp_valid), 64'd0);
    tick;
    cpl(0, 0);
    sb.push_back(8'h20);
    tick;
    cpl_valid = '0;
    tick;
    half;
    chk("t3_idle", 64'(idle), 64'd1);

    // 4: out-of-range intf_id completes immediately
    tick;
    send(8'h44, 4'd7);
    sb.push_back(8'h44);
    half;
    chk("t4_ready", 64'(cmd_ready), 64'd1);
    tick;
    cmd_valid = 1'b0;
    half;
    chk("t4_resp", 64'(resp_valid), 64'd1);
    chk("t4_rqv", 64'(rq_valid), 64'd0);
    tick;
    half;
    chk("t4_resp_off", 64'(resp_valid), 64'd0);
    chk("t4_idle", 64'(idle), 64'd1);

    // 5: spurious completion, then async reset
    tick;
    cpl(0, 4);
    tick;
    cpl_valid = '0;
    half;
    chk("t5_spur", 64'(spur), 64'd1);
    chk("t5_no_resp", 64'(resp_valid), 64'd0);
    tick;
    half;
    chk("t5_spur_hold", 64'(spur), 64'd1);
    tick;
    rst = 1'b1;
    #1;
    chk("t5_async_spur", 64'(spur), 64'd0);
    chk("t5_async_idle", 64'(idle), 64'd1);
    do_reset;

    // 6: dispatch stall
    rq_ready = 2'b00;
    send(8'h60, 4'd0);
    tick;
    send(8'h61, 4'd1);
    for (int i = 0; i < 5; i++) begin
      half;
      chk("t6_rqv", 64'(rq_valid), 64'b01);
      chk("t6_tag", 64'(rq_tag), 64'd0);
      chk("t6_id", 64'(rq.cmd_id), 64'h60);
      chk("t6_blocked", 64'(cmd_ready), 64'd0);
      tick;
    end
    rq_ready = 2'b01;
    half;
    chk("t6_ready", 64'(cmd_ready), 64'd1);
    tick;
    cmd_valid = 1'b0;
    rq_ready  = 2'b11;
    half;
    chk("t6_rqv_b", 64'(rq_valid), 64'b10);
    chk("t6_tag_b", 64'(rq_tag), 64'd1);
    chk("t6_id_b", 64'(rq.cmd_id), 64'h61);
    tick;
    cpl(0, 0);
    cpl(1, 1);
    sb.push_back(8'h60);
    sb.push_back(8'h61);
    tick;
    cpl_valid = '0;
    tick;
    tick;
    half;
    chk("t6_idle", 64'(idle), 64'd1);

    // 7: completion in the dispatch handshake cycle
    tick;
    rq_ready = 2'b01;
    send(8'h70, 4'd0);
    tick;
    cmd_valid = 1'b0;
    cpl(0, 0);
    sb.push_back(8'h70);
    tick;
    cpl_valid = '0;
    half;
    chk("t7_resp", 64'(resp_valid), 64'd1);
    chk("t7_spur", 64'(spur), 64'd0);
    tick;
    half;
    chk("t7_idle", 64'(idle), 64'd1);

    repeat (3) tick;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
